// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and add/sub opcode values.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/slice_addsub.sv
// One SLICE_W-bit adder/subtractor slice, shared across all slices of an operand.
// Exposes the MSB-level operands (after B inversion) so the caller can form signed overflow.
module slice_addsub
    import alu_pkg::*;
#(
    parameter int unsigned SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    input  logic               op,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               msb_a,
    output logic               msb_b
);

    logic [SLICE_W:0]   add_full;
    logic [SLICE_W:0]   sub_full;
    logic [SLICE_W-1:0] b_eff;

    // Form both add and subtract paths, then carry-select the one requested by op
    always_comb begin
        add_full = {1'b0, a} + {1'b0, b}  + {{SLICE_W{1'b0}}, cin};
        sub_full = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, cin};
        b_eff    = (op == OP_SUB) ? ~b : b;
        if (op == OP_SUB) begin
            sum  = sub_full[SLICE_W-1:0];
            cout = sub_full[SLICE_W];
        end else begin
            sum  = add_full[SLICE_W-1:0];
            cout = add_full[SLICE_W];
        end
        msb_a = a[SLICE_W-1];
        msb_b = b_eff[SLICE_W-1];
    end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Multi-cycle add/subtract sequencer: walks a full-width operation through one shared
// slice, least-significant slice first, carrying between slices in a register.
module addsub_seq_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned SLICE_W    = 8,
    parameter int unsigned NUM_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_op,
    input  logic [SLICE_W*NUM_SLICES-1:0] req_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] req_b,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] resp_result,
    output logic                          resp_carry,
    output logic                          resp_overflow
);

    localparam int unsigned W     = SLICE_W * NUM_SLICES;
    localparam int unsigned IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_t             state;
    state_t             state_next;
    logic               op_q;
    logic               carry_q;
    logic               ov_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       res_q;
    logic [IDX_W-1:0]   idx_q;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] sum_sl;
    logic               cout_sl;
    logic               msb_a;
    logic               msb_b;
    logic               accept;
    logic               last;

    slice_addsub #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a     (a_sl),
        .b     (b_sl),
        .cin   (carry_q),
        .op    (op_q),
        .sum   (sum_sl),
        .cout  (cout_sl),
        .msb_a (msb_a),
        .msb_b (msb_b)
    );

    // Select the current slice of the latched operands
    always_comb begin
        a_sl = a_q[idx_q*SLICE_W +: SLICE_W];
        b_sl = b_q[idx_q*SLICE_W +: SLICE_W];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs decoded from the registered state
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (idx_q == LAST_IDX) begin
                    last       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latch, per-slice result/carry update and final-slice overflow capture
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            ov_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            op_q    <= req_op;
            a_q     <= req_a;
            b_q     <= req_b;
            carry_q <= req_op;
            idx_q   <= '0;
        end else if (state == ST_RUN) begin
            res_q[idx_q*SLICE_W +: SLICE_W] <= sum_sl;
            carry_q <= cout_sl;
            if (last) begin
                ov_q <= (msb_a == msb_b) && (sum_sl[SLICE_W-1] != msb_a);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign resp_result   = res_q;
    assign resp_carry    = carry_q;
    assign resp_overflow = ov_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl: expected responses are queued at request
// acceptance and checked by an independent monitor whenever the DUT presents a response.
module tb_addsub_seq_ctrl;

    localparam int unsigned SLICE_W    = 8;
    localparam int unsigned NUM_SLICES = 4;
    localparam int unsigned W          = SLICE_W * NUM_SLICES;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_op = 1'b0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         resp_ready = 1'b0;
    logic         req_ready;
    logic         resp_valid;
    logic [W-1:0] resp_result;
    logic         resp_carry;
    logic         resp_overflow;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   timeouts = 0;
    bit   finish_req = 1'b0;
    bit   final_done = 1'b0;
    bit   rst_prev = 1'b0;
    bit   prev_valid = 1'b0;
    bit   after_xfer = 1'b0;
    exp_t exp_q[$];
    int   acc_q[$];

    addsub_seq_ctrl #(
        .SLICE_W    (SLICE_W),
        .NUM_SLICES (NUM_SLICES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_carry    (resp_carry),
        .resp_overflow (resp_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-width arithmetic, borrow as unsigned compare, overflow from operand/result signs
    function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] wide;
        if (!op) begin
            wide = {1'b0, a} + {1'b0, b};
            e.r  = wide[W-1:0];
            e.c  = wide[W];
            e.ov = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
        end else begin
            e.r  = a - b;
            e.c  = (a >= b);
            e.ov = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: scoreboard push on acceptance, compare/pop on response, protocol checks
    always @(negedge clk) begin
        if (rst_prev) begin
            chk("reset_req_ready", req_ready, 1);
            chk("reset_resp_valid", resp_valid, 0);
            chk("reset_result", resp_result, 0);
            chk("reset_carry", resp_carry, 0);
            chk("reset_overflow", resp_overflow, 0);
        end
        rst_prev = rst;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            after_xfer = 1'b0;
        end else begin
            if (after_xfer) begin
                chk("ready_after_xfer", req_ready, 1);
                chk("valid_after_xfer", resp_valid, 0);
                after_xfer = 1'b0;
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_resp actual=resp_valid_1 required=no_response result=%h", resp_result);
                end else begin
                    if (!prev_valid && acc_q.size() > 0) begin
                        chk("latency", W'(cyc - acc_q[0]), W'(NUM_SLICES));
                        void'(acc_q.pop_front());
                    end
                    chk("result", resp_result, exp_q[0].r);
                    chk("carry", resp_carry, exp_q[0].c);
                    chk("overflow", resp_overflow, exp_q[0].ov);
                    chk("req_ready_in_done", req_ready, 0);
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        after_xfer = 1'b1;
                    end
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(model(req_op, req_a, req_b));
                acc_q.push_back(cyc + 1);
            end
        end
        prev_valid = resp_valid && !rst;
        if (finish_req && !final_done) begin
            chk("wait_timeouts", W'(timeouts), 0);
            chk("pending_responses", W'(exp_q.size()), 0);
            final_done = 1'b1;
        end
    end

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Present a request (entered just after a rising edge) and wait until it is accepted
    task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        if (!req_ready) timeouts++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 100);
        if (!resp_valid) timeouts++;
    endtask

    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
        resp_ready = (stall == 0);
        send(op, a, b);
        req_valid = 1'b0;
        req_op    = 1'($urandom_range(0, 1));
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        wait_resp();
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            @(posedge clk);
            #1 resp_ready = 1'b1;
        end
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic reset_mid_op();
        resp_ready = 1'b1;
        send(1'b0, 32'h1234_5678, 32'h1111_1111);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic back_to_back(input logic op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                                input logic op2, input logic [W-1:0] a2, input logic [W-1:0] b2);
        resp_ready = 1'b1;
        send(op1, a1, b1);
        send(op2, a2, b2);
        req_valid = 1'b0;
        wait_resp();
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 0);
        run_op(1'b1, 32'h0000_0000, 32'h0000_0001, 0);
        run_op(1'b1, 32'h0000_0005, 32'h0000_0003, 0);
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 0);
        run_op(1'b0, 32'hA5A5_F00F, 32'h5A5A_0FF1, 10);
        reset_mid_op();
        run_op(1'b0, 32'h0000_0001, 32'h0000_0001, 0);
        back_to_back(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h0000_0010, 32'h0000_0020);

        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 1)), rand_operand(), rand_operand(), int'($urandom_range(0, 3)));
        end

        finish_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
